dm_port_arbiter: RTL and testbench

Shares one single-port synchronous data memory (1-cycle registered read latency) between two processor cores. Each core issues a read or write request with a level-held req. The arbiter picks one core by round-robin, sequences the access through a 3-state FSM, and returns a one-cycle ack together with the read data. It sits between both cores' AR/DR/mem_write outputs and the shared data RAM.

---
 rtl/dm_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dm_port_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous data RAM between two cores.
// Each access runs IDLE -> ACCESS -> READ_WAIT, and a one-cycle ack is returned in the following IDLE cycle.
module dm_port_arbiter #(
   parameter int addr_width = 12,
   parameter int data_width = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req0,
   input  logic                  we0,
   input  logic [addr_width-1:0] addr0,
   input  logic [data_width-1:0] wdata0,
   output logic                  ack0,
   output logic [data_width-1:0] rdata0,
   input  logic                  req1,
   input  logic                  we1,
   input  logic [addr_width-1:0] addr1,
   input  logic [data_width-1:0] wdata1,
   output logic                  ack1,
   output logic [data_width-1:0] rdata1,
   output logic [addr_width-1:0] mem_addr,
   output logic [data_width-1:0] mem_data,
   output logic                  mem_wren,
   input  logic [data_width-1:0] mem_q,
   output logic                  grant,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ACCESS    = 2'd1,
      READ_WAIT = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic                  grant_q, grant_d;
   logic                  lastGrant_q, lastGrant_d;
   logic                  weLat_q, weLat_d;
   logic                  ack0_q, ack0_d;
   logic                  ack1_q, ack1_d;
   logic [addr_width-1:0] memAddr_q, memAddr_d;
   logic [data_width-1:0] memData_q, memData_d;
   logic [data_width-1:0] rdata0_q, rdata0_d;
   logic [data_width-1:0] rdata1_q, rdata1_d;

   logic effReq0, effReq1, start, winner;

   // A request is masked in its own ack cycle so a held req is not served twice in a row.
   always_comb begin
      effReq0 = req0 & ~ack0_q;
      effReq1 = req1 & ~ack1_q;
      start   = (state_q == IDLE) && (effReq0 || effReq1);
      winner  = (effReq0 && effReq1) ? ~lastGrant_q : effReq1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      if (start) state_d = ACCESS;
         ACCESS:    state_d = READ_WAIT;
         READ_WAIT: state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Writes also pass through READ_WAIT so both access kinds share the same latency.
   always_comb begin
      grant_d     = grant_q;
      lastGrant_d = lastGrant_q;
      weLat_d     = weLat_q;
      memAddr_d   = memAddr_q;
      memData_d   = memData_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      if (start) begin
         grant_d     = winner;
         lastGrant_d = winner;
         weLat_d     = winner ? we1 : we0;
         memAddr_d   = winner ? addr1 : addr0;
         memData_d   = winner ? wdata1 : wdata0;
      end
      if (state_q == READ_WAIT) begin
         if (grant_q) begin
            ack1_d = 1'b1;
            if (!weLat_q) rdata1_d = mem_q;
         end else begin
            ack0_d = 1'b1;
            if (!weLat_q) rdata0_d = mem_q;
         end
      end
   end

   // lastGrant resets to 1 so that core 0 wins the first tie.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         grant_q     <= 1'b0;
         lastGrant_q <= 1'b1;
         weLat_q     <= 1'b0;
         ack0_q      <= 1'b0;
         ack1_q      <= 1'b0;
         memAddr_q   <= '0;
         memData_q   <= '0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         grant_q     <= grant_d;
         lastGrant_q <= lastGrant_d;
         weLat_q     <= weLat_d;
         ack0_q      <= ack0_d;
         ack1_q      <= ack1_d;
         memAddr_q   <= memAddr_d;
         memData_q   <= memData_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   always_comb begin
      mem_wren = (state_q == ACCESS) && weLat_q;
      busy     = (state_q != IDLE);
      mem_addr = memAddr_q;
      mem_data = memData_q;
      grant    = grant_q;
      ack0     = ack0_q;
      ack1     = ack1_q;
      rdata0   = rdata0_q;
      rdata1   = rdata1_q;
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter with a behavioural 1-cycle-latency RAM model.
// Inputs are driven and outputs sampled on the falling edge; cycle N is the cycle in which a request is first driven.
module tb_dm_port_arbiter;

   localparam int AW = 12;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0, we0, req1, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata0, rdata1;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_wren;
   logic [DW-1:0] mem_q;
   logic          grant, busy;

   int checks = 0;
   int failures = 0;

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wren) mem[mem_addr] <= mem_data;
      mem_q <= mem[mem_addr];
   end

   dm_port_arbiter #(.addr_width(AW), .data_width(DW)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
      .grant(grant), .busy(busy)
   );

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({ack0, ack1, mem_wren, grant, busy} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000", {ack0, ack1, mem_wren, grant, busy});
      end
      checks++;
      if ({rdata0, rdata1, mem_addr, mem_data} !== 48'h0) begin
         failures++;
         $display("[TB] FAIL reset_data: got %h expected 0", {rdata0, rdata1, mem_addr, mem_data});
      end
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checks++;
         if (mem_wren !== 1'b0) begin
            failures++;
            $display("[TB] FAIL read_wren k=%0d: got %b expected 0", k, mem_wren);
         end
         checks++;
         if (ack0 !== (k == 3)) begin
            failures++;
            $display("[TB] FAIL read_ack0 k=%0d: got %b expected %b", k, ack0, (k == 3));
         end
         checks++;
         if (busy !== (k < 3)) begin
            failures++;
            $display("[TB] FAIL read_busy k=%0d: got %b expected %b", k, busy, (k < 3));
         end
         if (k == 1) begin
            checks++;
            if (mem_addr !== 12'h010 || grant !== 1'b0) begin
               failures++;
               $display("[TB] FAIL read_latch: got addr=%h grant=%b expected 010/0", mem_addr, grant);
            end
         end
         if (k == 3) begin
            checks++;
            if (rdata0 !== 12'hABC || ack1 !== 1'b0 || grant !== 1'b0) begin
               failures++;
               $display("[TB] FAIL read_data: got rdata0=%h ack1=%b grant=%b expected ABC/0/0", rdata0, ack1, grant);
            end
            req0 = 1'b0;
         end
      end
   endtask

   task automatic test_single_write();
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 12'h7FF; wdata1 = 12'h123;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (mem_wren !== (k == 1)) begin
            failures++;
            $display("[TB] FAIL write_wren k=%0d: got %b expected %b", k, mem_wren, (k == 1));
         end
         checks++;
         if (mem_addr !== 12'h7FF || mem_data !== 12'h123) begin
            failures++;
            $display("[TB] FAIL write_bus k=%0d: got %h/%h expected 7FF/123", k, mem_addr, mem_data);
         end
         // Late changes to the request fields must not reach the in-flight access.
         if (k == 1) begin
            wdata1 = 12'h555; addr1 = 12'h001;
         end
         if (k == 3) begin
            checks++;
            if (ack1 !== 1'b1 || ack0 !== 1'b0 || rdata1 !== 12'h000 || rdata0 !== 12'hABC || grant !== 1'b1) begin
               failures++;
               $display("[TB] FAIL write_ack: got ack1=%b ack0=%b rdata1=%h rdata0=%h grant=%b expected 1/0/000/ABC/1",
                        ack1, ack0, rdata1, rdata0, grant);
            end
            req1 = 1'b0;
         end
      end
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h7FF;
      repeat (3) @(negedge clk);
      checks++;
      if (ack1 !== 1'b1 || rdata1 !== 12'h123 || rdata0 !== 12'hABC) begin
         failures++;
         $display("[TB] FAIL write_readback: got ack1=%b rdata1=%h rdata0=%h expected 1/123/ABC", ack1, rdata1, rdata0);
      end
      req1 = 1'b0;
   endtask

   task automatic test_held_req();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checks++;
         if (ack0 !== (k == 3 || k == 7)) begin
            failures++;
            $display("[TB] FAIL held_ack0 k=%0d: got %b expected %b", k, ack0, (k == 3 || k == 7));
         end
         checks++;
         if (busy !== (k == 1 || k == 2 || k == 5 || k == 6)) begin
            failures++;
            $display("[TB] FAIL held_busy k=%0d: got %b expected %b", k, busy, (k == 1 || k == 2 || k == 5 || k == 6));
         end
         if (k == 7) req0 = 1'b0;
      end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h020; wdata0 = 12'h321;
      @(negedge clk);
      checks++;
      if (mem_wren !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midrst_pre_wren: got %b expected 1", mem_wren);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({mem_wren, busy, grant, ack0} !== 4'b0 || mem_addr !== 12'h0 || rdata0 !== 12'h0) begin
         failures++;
         $display("[TB] FAIL midrst_async: got wren/busy/grant/ack0=%b addr=%h rdata0=%h expected 0000/000/000",
                  {mem_wren, busy, grant, ack0}, mem_addr, rdata0);
      end
      req0 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (ack0 !== 1'b0 || mem_wren !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midrst_hold k=%0d: got ack0=%b wren=%b expected 0/0", k, ack0, mem_wren);
         end
      end
      checks++;
      if (mem[12'h020] !== 12'h000) begin
         failures++;
         $display("[TB] FAIL midrst_dropped: got mem[020]=%h expected 000", mem[12'h020]);
      end
      reset = 1'b0;
   endtask

   // Both cores hold req; the first tie after reset goes to core 0 and grants then alternate.
   task automatic test_back_to_back();
      logic expGrant;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h7FF;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         expGrant = 1'(((k - 1) / 3) % 2);
         if (k <= 24) begin
            checks++;
            if (grant !== expGrant) begin
               failures++;
               $display("[TB] FAIL b2b_grant k=%0d: got %b expected %b", k, grant, expGrant);
            end
         end
         checks++;
         if (ack0 !== ((k % 3 == 0) && !expGrant) || ack1 !== ((k % 3 == 0) && expGrant)) begin
            failures++;
            $display("[TB] FAIL b2b_ack k=%0d: got ack0=%b ack1=%b expected %b/%b",
                     k, ack0, ack1, ((k % 3 == 0) && !expGrant), ((k % 3 == 0) && expGrant));
         end
         if (k == 3) begin
            checks++;
            if (rdata0 !== 12'hABC || rdata1 !== 12'h000) begin
               failures++;
               $display("[TB] FAIL b2b_first: got rdata0=%h rdata1=%h expected ABC/000", rdata0, rdata1);
            end
         end
         if (k == 6) begin
            checks++;
            if (rdata1 !== 12'h123) begin
               failures++;
               $display("[TB] FAIL b2b_second: got rdata1=%h expected 123", rdata1);
            end
         end
         if (k == 24) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         if (k == 25) begin
            checks++;
            if (busy !== 1'b0) begin
               failures++;
               $display("[TB] FAIL b2b_idle: got busy=%b expected 0", busy);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
      mem[12'h010] = 12'hABC;
      reset = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
      test_reset();
      test_single_read();
      test_single_write();
      test_held_req();
      test_reset_mid_write();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
